fifo_ddr3_in_wr: RTL and testbench
==================================

# fifo_ddr3_in_wr

Write-side companion of the DDR3 read-out FIFO. It accepts a 64-bit user data stream, packs eight beats into one 512-bit word, and buffers up to DEPTH packed words. It then issues each buffered word as a write command on the MIG user interface at a self-incrementing, wrapping address. It sits between the capture/processing logic and the DDR3 controller, all on the controller's UI clock.

## Interface
- DEPTH, 16, packed-word buffer depth (power of two)
- ADDR_W, 28, DDR3 app address width
- BASE_ADDR, 28'h0000000, first write address and wrap target
- END_ADDR, 28'h0FFFFF8, address of last burst before wrap (multiple of 8)

- clk  in  1  UI clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- din  in  64  user data beat
- din_vld  in  1  beat valid
- din_rdy  out  1  beat accepted when din_vld & din_rdy
- flush  in  1  single-cycle pulse; close a partial word
- app_rdy  in  1  MIG command ready
- app_wdf_rdy  in  1  MIG write-data ready
- app_en  out  1  command valid
- app_cmd  out  3  constant 3'b000 (write)
- app_addr  out  ADDR_W  write address
- app_wdf_data  out  512  write data
- app_wdf_mask  out  64  byte mask, 1 = byte not written
- app_wdf_wren  out  1  write-data valid
- app_wdf_end  out  1  equals app_wdf_wren (one beat per burst)
- data_count  out  log2(DEPTH)+1  packed words held in buffer
- wr_words  out  32  completed writes since reset, wraps at 2^32

## Operation
- Packer: a beat counter bcnt runs 0..7. Beat k lands in bits [64k+63:64k], so the first beat is at the LSBs.
- din_rdy = (data_count < DEPTH). It does not depend on din_vld.
- When the 8th beat is accepted, {din, pack[447:0]} is written to the buffer with mask 0 in the same edge, and bcnt returns to 0.
- Flush: a pulse with bcnt>0 sets flush_pend. flush_pend executes on the first cycle with data_count < DEPTH. It pushes the partial word with unfilled beats zeroed and mask bits for unfilled bytes set to 1, then clears bcnt.
- A flush with bcnt==0 and no pending beat is ignored.
- A beat accepted in the same cycle as flush is included in the flushed word. If that beat is the 8th, a normal full word is pushed and the flush is dropped.
- While flush_pend is set, din_rdy is 0.
- Buffer: synchronous FIFO of {mask, data}, registered read port, DEPTH entries. Push and pop in the same cycle leave data_count unchanged.
- Write FSM:
  - IDLE: if buffer non-empty, go to SEND; app_en and app_wdf_wren go high next cycle.
  - SEND: app_en=1, app_wdf_wren=1. Command is taken on app_en&app_rdy; data is taken on app_wdf_wren&app_wdf_rdy.
    - Both taken in the same cycle -> DONE action.
    - Only command taken -> WAIT_D.
    - Only data taken -> WAIT_C.
  - WAIT_D: app_wdf_wren=1 only; on app_wdf_rdy -> DONE action.
  - WAIT_C: app_en=1 only; on app_rdy -> DONE action.
  - DONE action (same edge): pop the buffer, increment wr_words, and advance app_addr = (app_addr==END_ADDR) ? BASE_ADDR : app_addr+8. Next state is SEND if the buffer still holds a word after the pop, else IDLE.
- app_addr, app_wdf_data and app_wdf_mask hold stable from the assertion of app_en/app_wdf_wren until DONE.

## Timing
- Reset values:
  - app_en, app_wdf_wren, app_wdf_end, din_rdy: 0 during reset, din_rdy 1 after.
  - app_wdf_data, app_wdf_mask: 0.
  - app_addr: BASE_ADDR.
  - data_count, wr_words, bcnt, flush_pend: 0.
  - FSM: IDLE.
- Reset asserted mid-operation clears all state immediately, including buffered words, which are discarded. app_en and app_wdf_wren drop without waiting for a handshake.
- Latency: 8th beat accepted at edge N -> data_count increments at N -> app_en/app_wdf_wren high after edge N+1.
- Throughput: with both readies held high, one write per cycle back-to-back; a new SEND follows DONE with no idle cycle.
- With the buffer full and readies low, din_rdy stays 0 until the DONE edge. It is 1 in the following cycle.

## Test plan
- Reset, then 8 beats 64'h0..64'h7 with readies high -> one write at BASE_ADDR, data {7,...,0}, mask 0, wr_words=1, data_count back to 0.
- Hold app_rdy=0 for 5 cycles with app_wdf_rdy=1 -> app_wdf_wren high 1 cycle, app_en held 6 cycles, addr/data stable, a single pop.
- Readies low, push 16 words (128 beats) -> data_count=16, din_rdy=0. The 129th beat is not accepted. Release readies -> 16 writes at consecutive addresses BASE..BASE+120, data intact.
- 3 beats then flush -> one write, beats 0..2 in low 192 bits, upper bits 0, app_wdf_mask=64'hFFFF_FFFF_FF00_0000.
- Preload app_addr near END_ADDR via writes -> the write at END_ADDR is followed by a write at BASE_ADDR.
- Assert rst_n=0 while in WAIT_C with 4 words buffered -> app_en=0 immediately, data_count=0, app_addr=BASE_ADDR after release.

Source files
------------

// File: rtl/fifo_ddr3_in_wr.sv
// Packs a 64-bit beat stream into 512-bit words, buffers them and writes each
// buffered word to the MIG user interface at a self-incrementing, wrapping address.
module fifo_ddr3_in_wr #(
  parameter int unsigned      DEPTH     = 16,
  parameter int unsigned      ADDR_W    = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 28'h0000000,
  parameter logic [ADDR_W-1:0] END_ADDR  = 28'h0FFFFF8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              din,
  input  logic                     din_vld,
  output logic                     din_rdy,
  input  logic                     flush,
  input  logic                     app_rdy,
  input  logic                     app_wdf_rdy,
  output logic                     app_en,
  output logic [2:0]               app_cmd,
  output logic [ADDR_W-1:0]        app_addr,
  output logic [511:0]             app_wdf_data,
  output logic [63:0]              app_wdf_mask,
  output logic                     app_wdf_wren,
  output logic                     app_wdf_end,
  output logic [$clog2(DEPTH):0]   data_count,
  output logic [31:0]              wr_words
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = 576;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_D, WAIT_C} state_t;

  state_t            state;
  logic [2:0]        bcnt;
  logic [511:0]      pack;
  logic              flush_pend;
  logic [EW-1:0]     mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;

  logic              acc;
  logic              full_push;
  logic              flush_req;
  logic              do_flush;
  logic              push;
  logic              pend_nxt;
  logic              done;
  logic [511:0]      pack_ins;
  logic [63:0]       push_mask;
  logic [3:0]        fill;
  logic [CW-1:0]     count_nxt;
  logic [PW-1:0]     rptr_nxt;
  logic [EW-1:0]     next_head;

  assign app_cmd     = 3'b000;
  assign app_wdf_end = app_wdf_wren;

  // Packer: current beat lands in its slot; unfilled beats are masked off.
  always_comb begin
    pack_ins = pack;
    if (acc) pack_ins[{bcnt, 6'd0} +: 64] = din;
    fill = {1'b0, bcnt} + {3'b000, acc};
    for (int k = 0; k < 8; k++) begin
      push_mask[8*k +: 8] = (4'(k) >= fill) ? 8'hFF : 8'h00;
    end
  end

  assign acc       = din_vld & din_rdy;
  assign full_push = acc & (bcnt == 3'd7);
  assign flush_req = flush & ((bcnt != 3'd0) | acc) & ~full_push;
  assign do_flush  = (flush_req | flush_pend) & (data_count < CW'(DEPTH));
  assign push      = full_push | do_flush;
  assign pend_nxt  = (flush_req | flush_pend) & ~do_flush;

  always_comb begin
    done = 1'b0;
    case (state)
      SEND:    done = app_rdy & app_wdf_rdy;
      WAIT_D:  done = app_wdf_rdy;
      WAIT_C:  done = app_rdy;
      default: done = 1'b0;
    endcase
  end

  assign count_nxt = data_count + CW'(push) - CW'(done);
  assign rptr_nxt  = rptr + PW'(1);
  // A word pushed on the same edge as the pop of the only entry is forwarded.
  assign next_head = (push && (wptr == rptr_nxt)) ? {push_mask, pack_ins} : mem[rptr_nxt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt       <= '0;
      pack       <= '0;
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= pend_nxt;
      if (push) begin
        bcnt <= '0;
        pack <= '0;
      end else if (acc) begin
        bcnt <= bcnt + 3'd1;
        pack <= pack_ins;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {push_mask, pack_ins};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      data_count <= '0;
      din_rdy    <= 1'b0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (done) rptr <= rptr_nxt;
      data_count <= count_nxt;
      din_rdy    <= (count_nxt < CW'(DEPTH)) & ~pend_nxt;
    end
  end

  // Write FSM: command and data handshakes may complete in either order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      app_en       <= 1'b0;
      app_wdf_wren <= 1'b0;
      app_addr     <= BASE_ADDR;
      app_wdf_data <= '0;
      app_wdf_mask <= '0;
      wr_words     <= '0;
    end else if (done) begin
      wr_words <= wr_words + 32'd1;
      app_addr <= (app_addr == END_ADDR) ? BASE_ADDR : app_addr + ADDR_W'(8);
      if (count_nxt != '0) begin
        state                        <= SEND;
        app_en                       <= 1'b1;
        app_wdf_wren                 <= 1'b1;
        {app_wdf_mask, app_wdf_data} <= next_head;
      end else begin
        state        <= IDLE;
        app_en       <= 1'b0;
        app_wdf_wren <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (data_count != '0) begin
            state                        <= SEND;
            app_en                       <= 1'b1;
            app_wdf_wren                 <= 1'b1;
            {app_wdf_mask, app_wdf_data} <= mem[rptr];
          end
        end
        SEND: begin
          if (app_rdy) begin
            state  <= WAIT_D;
            app_en <= 1'b0;
          end else if (app_wdf_rdy) begin
            state        <= WAIT_C;
            app_wdf_wren <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ddr3_in_wr.sv
// Directed bench for fifo_ddr3_in_wr: packing, flush, back-pressure, wrap and reset.
module tb_fifo_ddr3_in_wr;

  localparam logic [27:0] BASE = 28'h0001000;
  localparam logic [27:0] ENDA = 28'h00010C0;

  logic         clk;
  logic         rst_n;
  logic [63:0]  din;
  logic         din_vld;
  logic         din_rdy;
  logic         flush;
  logic         app_rdy;
  logic         app_wdf_rdy;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic [511:0] app_wdf_data;
  logic [63:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [4:0]   data_count;
  logic [31:0]  wr_words;

  fifo_ddr3_in_wr #(
    .DEPTH(16), .ADDR_W(28), .BASE_ADDR(BASE), .END_ADDR(ENDA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .flush(flush), .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en),
    .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_data(app_wdf_data),
    .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .data_count(data_count), .wr_words(wr_words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MIG-side model: a write completes once both its command and data are taken.
  logic [27:0]  log_addr [128];
  logic [511:0] log_data [128];
  logic [63:0]  log_mask [128];
  int           nlog = 0;
  logic         got_c = 1'b0;
  logic         got_d = 1'b0;
  logic [27:0]  c_addr;
  logic [511:0] d_data;
  logic [63:0]  d_mask;
  wire          c_tk = app_en & app_rdy;
  wire          d_tk = app_wdf_wren & app_wdf_rdy;

  always @(posedge clk) begin
    if (!rst_n) begin
      got_c <= 1'b0;
      got_d <= 1'b0;
    end else begin
      if (c_tk) c_addr <= app_addr;
      if (d_tk) begin
        d_data <= app_wdf_data;
        d_mask <= app_wdf_mask;
      end
      if ((got_c || c_tk) && (got_d || d_tk)) begin
        if (nlog < 128) begin
          log_addr[nlog] <= c_tk ? app_addr : c_addr;
          log_data[nlog] <= d_tk ? app_wdf_data : d_data;
          log_mask[nlog] <= d_tk ? app_wdf_mask : d_mask;
        end
        nlog  <= nlog + 1;
        got_c <= 1'b0;
        got_d <= 1'b0;
      end else begin
        if (c_tk) got_c <= 1'b1;
        if (d_tk) got_d <= 1'b1;
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d);
    int t;
    @(negedge clk);
    din     = d;
    din_vld = 1'b1;
    t = 0;
    while (!din_rdy && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("beat_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    din_vld = 1'b0;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int t;
    t = 0;
    while (nlog < target && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check(tag, nlog >= target, 1'b1);
  endtask

  function automatic logic [511:0] word(input logic [63:0] b0);
    logic [511:0] w;
    for (int k = 0; k < 8; k++) w[64*k +: 64] = b0 + 64'(k);
    return w;
  endfunction

  initial begin
    int base;
    int en_cnt;
    int wr_cnt;
    int stable_bad;
    int cyc;
    int t;
    logic [511:0] exp_w;

    rst_n = 1'b0; din = '0; din_vld = 1'b0; flush = 1'b0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_app_en", app_en, 1'b0);
    check("rst_wren", app_wdf_wren, 1'b0);
    check("rst_wdf_end", app_wdf_end, 1'b0);
    check("rst_din_rdy", din_rdy, 1'b0);
    check("rst_addr", app_addr, BASE);
    check("rst_count", data_count, 5'd0);
    check("rst_wr_words", wr_words, 32'd0);
    check("rst_data", app_wdf_data, 512'd0);
    check("rst_mask", app_wdf_mask, 64'd0);
    check("rst_cmd", app_cmd, 3'b000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_din_rdy", din_rdy, 1'b1);

    // Single full word with readies high
    base = nlog;
    for (int k = 0; k < 8; k++) beat(64'(k));
    idle();
    wait_writes(base + 1, "t1_write_timeout");
    repeat (3) @(negedge clk);
    check("t1_addr", log_addr[base], BASE);
    check("t1_data", log_data[base], word(64'd0));
    check("t1_mask", log_mask[base], 64'd0);
    check("t1_wr_words", wr_words, 32'd1);
    check("t1_count", data_count, 5'd0);

    // Command ready held low for 5 cycles
    app_rdy = 1'b0;
    base = nlog;
    for (int k = 0; k < 8; k++) beat(64'h100 + 64'(k));
    idle();
    t = 0;
    while (!app_en && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("t2_en_rise", app_en, 1'b1);
    en_cnt = 0; wr_cnt = 0; stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) app_rdy = 1'b1;
      en_cnt += int'(app_en);
      wr_cnt += int'(app_wdf_wren);
      if (app_en && (app_addr !== BASE + 28'd8 || app_wdf_data !== word(64'h100))) stable_bad++;
      @(negedge clk);
    end
    check("t2_en_cycles", en_cnt, 6);
    check("t2_wren_cycles", wr_cnt, 1);
    check("t2_stable", stable_bad, 0);
    check("t2_nwrites", nlog, base + 1);
    check("t2_addr", log_addr[base], BASE + 28'd8);
    check("t2_data", log_data[base], word(64'h100));
    check("t2_wr_words", wr_words, 32'd2);
    check("t2_count", data_count, 5'd0);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Fill the buffer with readies low, then drain back-to-back
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    base = nlog;
    for (int w = 0; w < 16; w++)
      for (int k = 0; k < 8; k++) beat(64'h1000 + 64'(w * 8 + k));
    idle();
    repeat (2) @(negedge clk);
    check("t3_full_count", data_count, 5'd16);
    check("t3_full_din_rdy", din_rdy, 1'b0);
    check("t3_full_app_en", app_en, 1'b1);
    @(negedge clk);
    din = 64'hDEAD; din_vld = 1'b1;
    repeat (3) @(negedge clk);
    din_vld = 1'b0;
    check("t3_extra_count", data_count, 5'd16);
    check("t3_no_write", nlog, base);
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    @(negedge clk);
    cyc = 1;
    check("t3_din_rdy_after_done", din_rdy, 1'b1);
    while (nlog < base + 16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t3_drain_cycles", cyc, 16);
    for (int i = 0; i < 16; i++) begin
      check("t3_addr", log_addr[base + i], BASE + 28'(i * 8));
      check("t3_data", log_data[base + i], word(64'h1000 + 64'(i * 8)));
    end
    check("t3_wr_words", wr_words, 32'd16);

    // Partial word closed by flush
    base = nlog;
    beat(64'hA0); beat(64'hA1); beat(64'hA2);
    idle();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    wait_writes(base + 1, "t4_write_timeout");
    exp_w = '0;
    exp_w[191:0] = {64'hA2, 64'hA1, 64'hA0};
    check("t4_addr", log_addr[base], BASE + 28'd128);
    check("t4_data", log_data[base], exp_w);
    check("t4_mask", log_mask[base], 64'hFFFF_FFFF_FF00_0000);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_empty_flush_ignored", nlog, base + 1);

    // Beat accepted together with flush is part of the flushed word
    base = nlog;
    beat(64'hB0); beat(64'hB1);
    @(negedge clk);
    din = 64'hB2; din_vld = 1'b1; flush = 1'b1;
    check("t4b_din_rdy", din_rdy, 1'b1);
    @(negedge clk);
    din_vld = 1'b0; flush = 1'b0;
    wait_writes(base + 1, "t4b_write_timeout");
    exp_w = '0;
    exp_w[191:0] = {64'hB2, 64'hB1, 64'hB0};
    check("t4b_addr", log_addr[base], BASE + 28'd136);
    check("t4b_data", log_data[base], exp_w);
    check("t4b_mask", log_mask[base], 64'hFFFF_FFFF_FF00_0000);

    // Address wrap; flush on the 8th beat of the last word is dropped
    base = nlog;
    for (int w = 0; w < 7; w++)
      for (int k = 0; k < 8; k++) beat(64'h2000 + 64'(w * 8 + k));
    for (int k = 0; k < 7; k++) beat(64'h2000 + 64'(56 + k));
    @(negedge clk);
    din = 64'h2000 + 64'd63; din_vld = 1'b1; flush = 1'b1;
    @(negedge clk);
    din_vld = 1'b0; flush = 1'b0;
    wait_writes(base + 8, "t5_write_timeout");
    repeat (10) @(negedge clk);
    check("t5_nwrites", nlog, base + 8);
    check("t5_addr_end", log_addr[base + 6], ENDA);
    check("t5_addr_wrap", log_addr[base + 7], BASE);
    check("t5_last_data", log_data[base + 7], word(64'h2000 + 64'd56));
    check("t5_last_mask", log_mask[base + 7], 64'd0);
    check("t5_wr_words", wr_words, 32'd26);
    check("t5_count", data_count, 5'd0);

    // Reset while waiting for the command handshake with words buffered
    app_rdy = 1'b0; app_wdf_rdy = 1'b1;
    base = nlog;
    for (int i = 0; i < 32; i++) beat(64'h3000 + 64'(i));
    idle();
    repeat (3) @(negedge clk);
    check("t6_count", data_count, 5'd4);
    check("t6_app_en", app_en, 1'b1);
    check("t6_wren", app_wdf_wren, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_app_en", app_en, 1'b0);
    check("t6_rst_count", data_count, 5'd0);
    check("t6_rst_wren", app_wdf_wren, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    app_rdy = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_addr", app_addr, BASE);
    check("t6_idle_app_en", app_en, 1'b0);
    check("t6_post_count", data_count, 5'd0);
    check("t6_wr_words", wr_words, 32'd0);
    check("t6_no_write", nlog, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
